// File: rtl/shift_arb.sv
// Two-requester round-robin arbiter in front of a single 32-bit barrel shifter.
// The result register is a one-entry slot that can be refilled in the cycle it drains.
module shift_arb (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Req0_Valid,
   output logic        Req0_Ready,
   input  logic [31:0] Req0_X,
   input  logic [4:0]  Req0_Sa,
   input  logic        Req0_Arith,
   input  logic        Req0_Right,
   input  logic        Req1_Valid,
   output logic        Req1_Ready,
   input  logic [31:0] Req1_X,
   input  logic [4:0]  Req1_Sa,
   input  logic        Req1_Arith,
   input  logic        Req1_Right,
   output logic        Rsp_Valid,
   input  logic        Rsp_Ready,
   output logic [31:0] Rsp_Sh,
   output logic        Rsp_Id
);

   // Handshake: a transfer happens on a rising edge where Valid & Ready are both high.
   // Ready depends on Valid, never the other way round.
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t      state_q, state_d;
   logic        last_q;
   logic [31:0] sh_q;
   logic        id_q;

   logic        free;
   logic        grant0, grant1;
   logic        xfer;
   logic        sel;
   logic [31:0] op_x;
   logic [4:0]  op_sa;
   logic        op_arith, op_right;
   logic        fill;
   logic signed [32:0] ext;
   logic signed [32:0] right_res;
   logic [31:0] sh_res;

   // Slot is free when empty or when the held result leaves this cycle.
   assign free = !Rst && ((state_q == EMPTY) || Rsp_Ready);

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (Req0_Valid && Req1_Valid) begin
         grant1 = (last_q == 1'b0);
         grant0 = (last_q == 1'b1);
      end else if (Req0_Valid) begin
         grant0 = 1'b1;
      end else if (Req1_Valid) begin
         grant1 = 1'b1;
      end
   end

   assign Req0_Ready = grant0 && free;
   assign Req1_Ready = grant1 && free;
   assign xfer       = Req0_Ready || Req1_Ready;
   assign sel        = grant1;

   assign op_x     = sel ? Req1_X     : Req0_X;
   assign op_sa    = sel ? Req1_Sa    : Req0_Sa;
   assign op_arith = sel ? Req1_Arith : Req0_Arith;
   assign op_right = sel ? Req1_Right : Req0_Right;

   // Single shared shifter; right shifts carry the fill bit in an extra MSB.
   assign fill      = op_x[31] && op_arith;
   assign ext       = $signed({fill, op_x});
   assign right_res = ext >>> op_sa;
   assign sh_res    = op_right ? right_res[31:0] : (op_x << op_sa);

   always_comb begin
      state_d = state_q;
      if (xfer) begin
         state_d = FULL;
      end else if ((state_q == FULL) && Rsp_Ready) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= EMPTY;
         sh_q    <= 32'h0;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         if (xfer) begin
            sh_q   <= sh_res;
            id_q   <= sel;
            last_q <= sel;
         end
      end
   end

   assign Rsp_Valid = (state_q == FULL);
   assign Rsp_Sh    = sh_q;
   assign Rsp_Id    = id_q;

endmodule

// File: tb/tb_shift_arb.sv
// Directed bench for shift_arb: expected results are queued at issue time and a
// monitor pops and compares each delivered result.
module tb_shift_arb;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Req0_Valid, Req0_Ready, Req0_Arith, Req0_Right;
   logic [31:0] Req0_X;
   logic [4:0]  Req0_Sa;
   logic        Req1_Valid, Req1_Ready, Req1_Arith, Req1_Right;
   logic [31:0] Req1_X;
   logic [4:0]  Req1_Sa;
   logic        Rsp_Valid, Rsp_Ready, Rsp_Id;
   logic [31:0] Rsp_Sh;

   logic [32:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   shift_arb dut (
      .Clk(Clk), .Rst(Rst),
      .Req0_Valid(Req0_Valid), .Req0_Ready(Req0_Ready), .Req0_X(Req0_X),
      .Req0_Sa(Req0_Sa), .Req0_Arith(Req0_Arith), .Req0_Right(Req0_Right),
      .Req1_Valid(Req1_Valid), .Req1_Ready(Req1_Ready), .Req1_X(Req1_X),
      .Req1_Sa(Req1_Sa), .Req1_Arith(Req1_Arith), .Req1_Right(Req1_Right),
      .Rsp_Valid(Rsp_Valid), .Rsp_Ready(Rsp_Ready), .Rsp_Sh(Rsp_Sh), .Rsp_Id(Rsp_Id)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next();
      @(posedge Clk);
      #1;
   endtask

   task automatic mid();
      @(negedge Clk);
   endtask

   task automatic set_req(input int n, input logic v, input logic [31:0] x,
                          input logic [4:0] sa, input logic ar, input logic rt);
      if (n == 0) begin
         Req0_Valid = v; Req0_X = x; Req0_Sa = sa; Req0_Arith = ar; Req0_Right = rt;
      end else begin
         Req1_Valid = v; Req1_X = x; Req1_Sa = sa; Req1_Arith = ar; Req1_Right = rt;
      end
   endtask

   task automatic push(input logic id, input logic [31:0] sh);
      exp_q.push_back({id, sh});
   endtask

   task automatic chk_ready(input string name, input logic r0, input logic r1);
      chk({name, "_r0"}, {32'h0, Req0_Ready}, {32'h0, r0});
      chk({name, "_r1"}, {32'h0, Req1_Ready}, {32'h0, r1});
   endtask

   // Monitor: each delivered result must match the oldest queued expectation.
   always @(negedge Clk) begin
      if (!Rst && Rsp_Valid && Rsp_Ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", {Rsp_Id, Rsp_Sh}, 33'h1_DEAD_DEAD);
         end else begin
            chk("rsp", {Rsp_Id, Rsp_Sh}, exp_q.pop_front());
         end
      end
   end

   typedef struct {
      int          n;
      logic [31:0] x;
      logic [4:0]  sa;
      logic        ar;
      logic        rt;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[5];

   initial begin
      vecs[0] = '{0, 32'h8000_0000, 5'd0,  1'b1, 1'b1, 32'h8000_0000};
      vecs[1] = '{1, 32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'h0000_0001};
      vecs[2] = '{0, 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF};
      vecs[3] = '{1, 32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF};
      vecs[4] = '{1, 32'h8000_0000, 5'd4,  1'b1, 1'b0, 32'h0000_0000};

      Rst = 1'b1;
      Rsp_Ready = 1'b0;
      set_req(0, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0);
      set_req(1, 1'b1, 32'h0, 5'd0, 1'b0, 1'b0);
      next();
      mid();
      chk_ready("in_reset", 1'b0, 1'b0);
      chk("rst_valid", {32'h0, Rsp_Valid}, 33'h0);
      chk("rst_sh_id", {Rsp_Id, Rsp_Sh}, 33'h0);
      next();

      // Arithmetic right shift, single requester.
      Rst = 1'b0;
      Rsp_Ready = 1'b1;
      set_req(1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
      set_req(0, 1'b1, 32'h8000_0001, 5'd4, 1'b1, 1'b1);
      push(1'b0, 32'hF800_0000);
      mid();
      chk_ready("first", 1'b1, 1'b0);
      next();
      Req0_Valid = 1'b0;
      mid();
      chk("lat1_valid", {32'h0, Rsp_Valid}, 33'h1);
      chk("lat1_data", {Rsp_Id, Rsp_Sh}, {1'b0, 32'hF800_0000});
      next();

      // Left shift from requester 1 moves the pointer to 1.
      set_req(1, 1'b1, 32'h0000_00FF, 5'd8, 1'b0, 1'b0);
      push(1'b1, 32'h0000_FF00);
      mid();
      chk_ready("req1_left", 1'b0, 1'b1);
      next();
      Req1_Valid = 1'b0;
      mid();
      next();
      mid();
      chk("drain_empty", {32'h0, Rsp_Valid}, 33'h0);
      next();

      // Both requesters continuously valid: grants alternate 0,1,0,1.
      set_req(0, 1'b1, 32'h1234_5678, 5'd4, 1'b0, 1'b0);
      set_req(1, 1'b1, 32'hF000_0000, 5'd4, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) push(1'b0, 32'h2345_6780);
         else            push(1'b1, 32'hFF00_0000);
         mid();
         chk_ready($sformatf("alt%0d", i), (i % 2 == 0), (i % 2 == 1));
         if (i > 0) chk($sformatf("alt%0d_valid", i), {32'h0, Rsp_Valid}, 33'h1);
         next();
      end

      // Consumer stalls for 3 cycles: result held, both requesters blocked.
      Rsp_Ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mid();
         chk($sformatf("hold%0d_data", i), {Rsp_Id, Rsp_Sh}, {1'b1, 32'hFF00_0000});
         chk($sformatf("hold%0d_valid", i), {32'h0, Rsp_Valid}, 33'h1);
         chk_ready($sformatf("hold%0d", i), 1'b0, 1'b0);
         next();
      end
      Rsp_Ready = 1'b1;
      push(1'b0, 32'h2345_6780);
      mid();
      chk_ready("unstall", 1'b1, 1'b0);
      next();
      Req0_Valid = 1'b0;
      Req1_Valid = 1'b0;
      mid();
      next();

      // Boundary shift amounts, back to back.
      foreach (vecs[k]) begin
         set_req(vecs[k].n, 1'b1, vecs[k].x, vecs[k].sa, vecs[k].ar, vecs[k].rt);
         push(vecs[k].n[0], vecs[k].exp);
         mid();
         chk_ready($sformatf("vec%0d", k), (vecs[k].n == 0), (vecs[k].n == 1));
         next();
         set_req(vecs[k].n, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
      end
      mid();
      next();

      // Fill the slot from requester 0, then reset while it is held.
      Rsp_Ready = 1'b0;
      set_req(0, 1'b1, 32'h0000_0003, 5'd1, 1'b0, 1'b0);
      mid();
      chk_ready("pre_rst", 1'b1, 1'b0);
      next();
      Req0_Valid = 1'b0;
      mid();
      chk("pre_rst_full", {32'h0, Rsp_Valid}, 33'h1);
      next();
      Rst = 1'b1;
      Req0_Valid = 1'b1;
      Req1_Valid = 1'b1;
      mid();
      chk_ready("rst_full", 1'b0, 1'b0);
      next();
      Rst = 1'b0;
      Req0_Valid = 1'b0;
      Req1_Valid = 1'b0;
      mid();
      chk("post_rst_valid", {32'h0, Rsp_Valid}, 33'h0);
      chk("post_rst_sh", {Rsp_Id, Rsp_Sh}, 33'h0);
      next();

      // Pointer reset to 1, so requester 0 wins the tie.
      Rsp_Ready = 1'b1;
      set_req(0, 1'b1, 32'h0000_00F0, 5'd4, 1'b0, 1'b1);
      set_req(1, 1'b1, 32'h0000_0001, 5'd1, 1'b0, 1'b0);
      push(1'b0, 32'h0000_000F);
      mid();
      chk_ready("post_rst_tie", 1'b1, 1'b0);
      next();
      Req0_Valid = 1'b0;
      Req1_Valid = 1'b0;
      mid();
      next();
      mid();
      chk("queue_empty", 33'(exp_q.size()), 33'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
